buffer_wr_arbiter: RTL and testbench

- Shares the write side of the circular buffer controller among `SRC_NUM` producers.
- Arbitrates producer requests round-robin and runs the controller's 4-phase `wr_req`/`wr_finish` handshakes for the selected producer.
- Routes that producer's write strobe, data and address to the controller while it holds the buffer.
- Sits in the write clock domain, between producer blocks and the controller's write interface.

---
 rtl/buf_arb_pkg.sv | 27 ++
 rtl/buf_arb_rr_pick.sv | 44 ++++
 rtl/buffer_wr_arbiter.sv | 242 ++++++++++++++++++++++++
 tb/tb_buffer_wr_arbiter.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/buf_arb_pkg.sv
// -----------------------------------------------------------------------------
// buf_arb_pkg
// Shared definitions for the buffer write-side arbiter:
//   - arb_state_e : FSM state encoding (IDLE=0 .. FIN_REL=5, 3 bits)
//   - log2()      : number of bits needed to represent a value (minimum 1),
//                   used for the producer index and watchdog counter widths.
// -----------------------------------------------------------------------------
package buf_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_REQ_REL = 3'd2,
    ST_GRANT   = 3'd3,
    ST_FIN     = 3'd4,
    ST_FIN_REL = 3'd5
  } arb_state_e;

  // Bits required to hold 'value' (log2(3)=2, log2(1)=1, log2(8)=4).
  function automatic int log2(input int value);
    int bits;
    bits = 1;
    while ((value >> bits) != 0) bits++;
    return bits;
  endfunction

endpackage

// File: rtl/buf_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// buf_arb_rr_pick
// Combinational round-robin selector. Searches req starting at last_src+1
// (modulo SRC_NUM) and returns the first set bit.
// Ports:
//   req      in  SRC_NUM       request vector
//   last_src in  SRC_ID_WIDTH  most recently served (or denied) producer
//   valid    out 1             at least one request is set
//   idx      out SRC_ID_WIDTH  selected producer
// -----------------------------------------------------------------------------
module buf_arb_rr_pick
  import buf_arb_pkg::*;
#(
  parameter  int SRC_NUM      = 4,
  localparam int SRC_ID_WIDTH = log2(SRC_NUM - 1)
) (
  input  logic [SRC_NUM-1:0]      req,
  input  logic [SRC_ID_WIDTH-1:0] last_src,
  output logic                    valid,
  output logic [SRC_ID_WIDTH-1:0] idx
);

  always_comb begin
    int                    cand;
    logic [SRC_ID_WIDTH-1:0] cand_idx;
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch cannot be inferred.
    valid    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    // Walk from the farthest offset to the nearest so the nearest hit
    // (highest priority) is the one that sticks.
    for (int off = SRC_NUM; off >= 1; off--) begin
      cand     = (int'(last_src) + off) % SRC_NUM;
      cand_idx = SRC_ID_WIDTH'(cand);
      if (req[cand_idx]) begin
        valid = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/buffer_wr_arbiter.sv
// -----------------------------------------------------------------------------
// buffer_wr_arbiter
// Shares the write side of the circular buffer controller among SRC_NUM
// producers. Requests are arbitrated round-robin; the selected producer's
// request/finish 4-phase handshakes are run against the controller and, while
// it owns a buffer, its write strobe/data/address are routed through.
//
// Optional feature: define BUF_WR_ARB_TIMEOUT_EN to enable an ack watchdog of
// TIMEOUT_CYCLES cycles that aborts a stalled handshake and sets a sticky
// timeout_err_o. Without it the FSM waits indefinitely and timeout_err_o is 0.
//
// Ports:
//   wr_clk_i, rst_n_i             clock, async active-low reset
//   src_req_i / src_grant_o       per-producer request level / one-hot ownership
//   src_deny_o                    1-cycle pulse: controller had no empty buffer
//   src_done_i                    1-cycle pulse from owner: buffer filled
//   src_wr_en_i/_data_i/_addr_i   per-producer write port (packed, 0 in LSBs)
//   wr_req_o/wr_req_ack_i/wr_req_result_i   request handshake to controller
//   wr_finish_o/wr_finish_ack_i             finish handshake to controller
//   wr_en_o/wr_data_o/wr_addr_o   muxed write port (combinational pass-through)
//   cur_src_o                     producer owning the current transaction
//   busy_o                        FSM not in IDLE
//   timeout_err_o                 sticky watchdog flag
// -----------------------------------------------------------------------------
module buffer_wr_arbiter
  import buf_arb_pkg::*;
#(
  parameter  int SRC_NUM          = 4,
  parameter  int WRITE_DATA_WIDTH = 8,
  parameter  int WRITE_ADDR_WIDTH = 8,
  parameter  int TIMEOUT_CYCLES   = 1024,
  localparam int SRC_ID_WIDTH     = log2(SRC_NUM - 1)
) (
  input  logic                                  wr_clk_i,
  input  logic                                  rst_n_i,
  input  logic [SRC_NUM-1:0]                    src_req_i,
  output logic [SRC_NUM-1:0]                    src_grant_o,
  output logic [SRC_NUM-1:0]                    src_deny_o,
  input  logic [SRC_NUM-1:0]                    src_done_i,
  input  logic [SRC_NUM-1:0]                    src_wr_en_i,
  input  logic [SRC_NUM*WRITE_DATA_WIDTH-1:0]   src_wr_data_i,
  input  logic [SRC_NUM*WRITE_ADDR_WIDTH-1:0]   src_wr_addr_i,
  output logic                                  wr_req_o,
  output logic                                  wr_finish_o,
  input  logic                                  wr_req_ack_i,
  input  logic                                  wr_req_result_i,
  input  logic                                  wr_finish_ack_i,
  output logic                                  wr_en_o,
  output logic [WRITE_DATA_WIDTH-1:0]           wr_data_o,
  output logic [WRITE_ADDR_WIDTH-1:0]           wr_addr_o,
  output logic [SRC_ID_WIDTH-1:0]               cur_src_o,
  output logic                                  busy_o,
  output logic                                  timeout_err_o
);

  if (SRC_NUM < 2) begin : g_bad_src_num
    $error("buffer_wr_arbiter: SRC_NUM must be at least 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("buffer_wr_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_e              state;
  logic [SRC_ID_WIDTH-1:0] cur_src;
  logic [SRC_ID_WIDTH-1:0] last_src;
  logic                    result;
  logic                    pick_valid;
  logic [SRC_ID_WIDTH-1:0] pick_idx;
  logic [SRC_NUM-1:0]      cur_onehot;
  logic                    timeout_hit;

  buf_arb_rr_pick #(
    .SRC_NUM (SRC_NUM)
  ) u_rr_pick (
    .req      (src_req_i),
    .last_src (last_src),
    .valid    (pick_valid),
    .idx      (pick_idx)
  );

  assign cur_onehot = SRC_NUM'(1) << cur_src;
  assign cur_src_o  = cur_src;

  // Write port: zero-latency pass-through; only the owner's strobe reaches
  // the controller, and only while it holds the buffer.
  assign wr_en_o = (state == ST_GRANT) && src_wr_en_i[cur_src];

  always_comb begin
    wr_data_o = '0;
    wr_addr_o = '0;
    for (int i = 0; i < SRC_NUM; i++) begin
      if (cur_src == SRC_ID_WIDTH'(i)) begin
        wr_data_o = src_wr_data_i[i*WRITE_DATA_WIDTH +: WRITE_DATA_WIDTH];
        wr_addr_o = src_wr_addr_i[i*WRITE_ADDR_WIDTH +: WRITE_ADDR_WIDTH];
      end
    end
  end

`ifdef BUF_WR_ARB_TIMEOUT_EN
  localparam int                    TO_WIDTH = log2(TIMEOUT_CYCLES);
  localparam logic [TO_WIDTH-1:0]   TO_LIMIT = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TO_WIDTH-1:0] to_cnt;
  logic                to_counting;
  logic                state_exit;
  logic                timeout_err_q;

  assign to_counting = state inside {ST_REQ, ST_REQ_REL, ST_FIN, ST_FIN_REL};

  // Normal handshake progress in the watched states; a regular exit on the
  // limit cycle wins over the watchdog.
  always_comb begin
    state_exit = 1'b0;
    case (state)
      ST_REQ:     state_exit = wr_req_ack_i;
      ST_REQ_REL: state_exit = !wr_req_ack_i;
      ST_FIN:     state_exit = wr_finish_ack_i;
      ST_FIN_REL: state_exit = !wr_finish_ack_i;
      default:    state_exit = 1'b0;
    endcase
  end

  assign timeout_hit = to_counting && !state_exit && (to_cnt == TO_LIMIT);

  // Every watched state is entered either from a non-watched state or via a
  // state_exit, so clearing on those events gives "clear on state entry".
  always_ff @(posedge wr_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      to_cnt        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (!to_counting || state_exit || timeout_hit) to_cnt <= '0;
      else                                           to_cnt <= to_cnt + 1'b1;
      if (timeout_hit) timeout_err_q <= 1'b1;
    end
  end

  assign timeout_err_o = timeout_err_q;
`else
  assign timeout_hit   = 1'b0;
  assign timeout_err_o = 1'b0;
`endif

  // Handshake FSM. All handshake/status outputs are registered and updated
  // together with the state they belong to.
  always_ff @(posedge wr_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: only control state is reset; the write data path is pure
      // combinational muxing and holds no storage.
      state       <= ST_IDLE;
      cur_src     <= '0;
      last_src    <= SRC_ID_WIDTH'(SRC_NUM - 1);
      result      <= 1'b0;
      wr_req_o    <= 1'b0;
      wr_finish_o <= 1'b0;
      src_grant_o <= '0;
      src_deny_o  <= '0;
      busy_o      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      src_deny_o <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            cur_src  <= pick_idx;
            wr_req_o <= 1'b1;
            busy_o   <= 1'b1;
            state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          // Result is only valid on the first ack-high cycle; the controller
          // clears it once the request drops.
          if (wr_req_ack_i) begin
            result   <= wr_req_result_i;
            wr_req_o <= 1'b0;
            state    <= ST_REQ_REL;
          end else if (timeout_hit) begin
            wr_req_o   <= 1'b0;
            src_deny_o <= cur_onehot;
            last_src   <= cur_src;
            busy_o     <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        ST_REQ_REL: begin
          if (!wr_req_ack_i) begin
            if (result) begin
              src_grant_o <= cur_onehot;
              state       <= ST_GRANT;
            end else begin
              // Denial rotates priority exactly like service does.
              src_deny_o <= cur_onehot;
              last_src   <= cur_src;
              busy_o     <= 1'b0;
              state      <= ST_IDLE;
            end
          end else if (timeout_hit) begin
            src_deny_o <= cur_onehot;
            last_src   <= cur_src;
            busy_o     <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (src_done_i[cur_src]) begin
            src_grant_o <= '0;
            wr_finish_o <= 1'b1;
            state       <= ST_FIN;
          end
        end
        ST_FIN: begin
          if (wr_finish_ack_i) begin
            wr_finish_o <= 1'b0;
            state       <= ST_FIN_REL;
          end else if (timeout_hit) begin
            wr_finish_o <= 1'b0;
            last_src    <= cur_src;
            busy_o      <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        ST_FIN_REL: begin
          if (!wr_finish_ack_i || timeout_hit) begin
            last_src <= cur_src;
            busy_o   <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: begin
          wr_req_o    <= 1'b0;
          wr_finish_o <= 1'b0;
          src_grant_o <= '0;
          busy_o      <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_buffer_wr_arbiter
// Self-checking bench for buffer_wr_arbiter (SRC_NUM=4, 8-bit data/address,
// TIMEOUT_CYCLES=8). A behavioural controller answers the request/finish
// handshakes with a 1-cycle ack; the expected owner order and the expected
// write-port values are kept in scoreboard queues.
// -----------------------------------------------------------------------------
module tb_buffer_wr_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int AW  = 8;
  localparam int TO  = 8;
  localparam int IDW = 2;

  logic            wr_clk_i = 1'b0;
  logic            rst_n_i  = 1'b0;
  logic [N-1:0]    src_req_i     = '0;
  logic [N-1:0]    src_grant_o;
  logic [N-1:0]    src_deny_o;
  logic [N-1:0]    src_done_i    = '0;
  logic [N-1:0]    src_wr_en_i   = '0;
  logic [N*DW-1:0] src_wr_data_i = '0;
  logic [N*AW-1:0] src_wr_addr_i = '0;
  logic            wr_req_o;
  logic            wr_finish_o;
  logic            wr_req_ack_i    = 1'b0;
  logic            wr_req_result_i;
  logic            wr_finish_ack_i = 1'b0;
  logic            wr_en_o;
  logic [DW-1:0]   wr_data_o;
  logic [AW-1:0]   wr_addr_o;
  logic [IDW-1:0]  cur_src_o;
  logic            busy_o;
  logic            timeout_err_o;

  int checks = 0;
  int errors = 0;

  bit ctrl_full      = 1'b0;
  bit ctrl_req_stall = 1'b0;
  bit ctrl_fin_stall = 1'b0;

  int          exp_src_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];

  buffer_wr_arbiter #(
    .SRC_NUM          (N),
    .WRITE_DATA_WIDTH (DW),
    .WRITE_ADDR_WIDTH (AW),
    .TIMEOUT_CYCLES   (TO)
  ) dut (
    .wr_clk_i        (wr_clk_i),
    .rst_n_i         (rst_n_i),
    .src_req_i       (src_req_i),
    .src_grant_o     (src_grant_o),
    .src_deny_o      (src_deny_o),
    .src_done_i      (src_done_i),
    .src_wr_en_i     (src_wr_en_i),
    .src_wr_data_i   (src_wr_data_i),
    .src_wr_addr_i   (src_wr_addr_i),
    .wr_req_o        (wr_req_o),
    .wr_finish_o     (wr_finish_o),
    .wr_req_ack_i    (wr_req_ack_i),
    .wr_req_result_i (wr_req_result_i),
    .wr_finish_ack_i (wr_finish_ack_i),
    .wr_en_o         (wr_en_o),
    .wr_data_o       (wr_data_o),
    .wr_addr_o       (wr_addr_o),
    .cur_src_o       (cur_src_o),
    .busy_o          (busy_o),
    .timeout_err_o   (timeout_err_o)
  );

  always #5 wr_clk_i = ~wr_clk_i;

  // Controller model: acks follow the request/finish levels one cycle later;
  // the result is valid only while ack is high.
  assign wr_req_result_i = wr_req_ack_i & ~ctrl_full;

  always @(negedge wr_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_req_ack_i    = 1'b0;
      wr_finish_ack_i = 1'b0;
    end else begin
      wr_req_ack_i    = ctrl_req_stall ? 1'b0 : wr_req_o;
      wr_finish_ack_i = ctrl_fin_stall ? 1'b0 : wr_finish_o;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- helpers
  task automatic do_reset();
    src_req_i     = '0;
    src_done_i    = '0;
    src_wr_en_i   = '0;
    ctrl_full      = 1'b0;
    ctrl_req_stall = 1'b0;
    ctrl_fin_stall = 1'b0;
    rst_n_i = 1'b0;
    repeat (2) @(negedge wr_clk_i);
    rst_n_i = 1'b1;
  endtask

  task automatic wait_owner(output logic [N-1:0] grant, output logic [N-1:0] deny);
    grant = '0;
    deny  = '0;
    for (int c = 0; c < 64; c++) begin
      @(negedge wr_clk_i);
      if (src_grant_o != '0 || src_deny_o != '0) begin
        grant = src_grant_o;
        deny  = src_deny_o;
        return;
      end
    end
  endtask

  // Pops the next expected owner and compares it with the grant the DUT gives.
  task automatic take_grant(output int src);
    logic [N-1:0] g, d, ev;
    int e;
    wait_owner(g, d);
    e  = (exp_src_q.size() > 0) ? exp_src_q.pop_front() : -1;
    ev = (e >= 0) ? (N'(1) << e) : '0;
    checks++;
    if (g !== ev || d !== '0) begin
      errors++;
      $display("FAIL grant_order: got grant=%b deny=%b, want grant=%b", g, d, ev);
    end
    src = e;
  endtask

  // Runs nwr writes for an owned producer (done on the last write), then
  // checks the finish handshake and the return to IDLE.
  task automatic serve(input int src, input int nwr, input bit keep_req);
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    int  fin_rises;
    bit  fin_prev;
    bit  idle_seen;
    for (int i = 0; i < nwr; i++) begin
      src_wr_en_i[src] = 1'b1;
      src_wr_addr_i[src*AW +: AW] = AW'(src * 32 + i);
      src_wr_data_i[src*DW +: DW] = DW'(8'h80 + src * 16 + i);
      exp_addr_q.push_back(AW'(src * 32 + i));
      exp_data_q.push_back(DW'(8'h80 + src * 16 + i));
      if (i == nwr - 1) begin
        src_done_i[src] = 1'b1;
        if (!keep_req) src_req_i[src] = 1'b0;
      end
      #1;
      ea = exp_addr_q.pop_front();
      ed = exp_data_q.pop_front();
      checks++;
      if (wr_en_o !== 1'b1 || wr_addr_o !== ea || wr_data_o !== ed || cur_src_o !== IDW'(src)) begin
        errors++;
        $display("FAIL write_pass src=%0d i=%0d: got en=%b addr=%h data=%h cur=%0d, want en=1 addr=%h data=%h cur=%0d",
                 src, i, wr_en_o, wr_addr_o, wr_data_o, cur_src_o, ea, ed, src);
      end
      @(negedge wr_clk_i);
    end
    src_wr_en_i[src] = 1'b0;
    src_done_i[src]  = 1'b0;
    checks++;
    if (src_grant_o !== '0 || wr_finish_o !== 1'b1 || wr_en_o !== 1'b0) begin
      errors++;
      $display("FAIL done_to_fin src=%0d: got grant=%b finish=%b en=%b, want grant=0 finish=1 en=0",
               src, src_grant_o, wr_finish_o, wr_en_o);
    end
    fin_rises = 1;
    fin_prev  = 1'b1;
    idle_seen = 1'b0;
    for (int c = 0; c < 32; c++) begin
      @(negedge wr_clk_i);
      if (wr_finish_o && !fin_prev) fin_rises++;
      fin_prev = wr_finish_o;
      if (!busy_o) begin
        idle_seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!idle_seen || fin_rises != 1) begin
      errors++;
      $display("FAIL finish_handshake src=%0d: got idle=%0d finish_pulses=%0d, want idle=1 finish_pulses=1",
               src, idle_seen, fin_rises);
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst_n_i = 1'b0;
    repeat (2) @(negedge wr_clk_i);
    checks++;
    if ({wr_req_o, wr_finish_o, src_grant_o, src_deny_o, busy_o, wr_en_o, cur_src_o, timeout_err_o} !== '0) begin
      errors++;
      $display("FAIL reset_values: got req=%b fin=%b grant=%b deny=%b busy=%b en=%b cur=%0d terr=%b, want all 0",
               wr_req_o, wr_finish_o, src_grant_o, src_deny_o, busy_o, wr_en_o, cur_src_o, timeout_err_o);
    end
    rst_n_i = 1'b1;
    @(negedge wr_clk_i);
  endtask

  task automatic test_single();
    int s;
    src_req_i = 4'b0010;
    @(negedge wr_clk_i);
    checks++;
    if (wr_req_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL single_req_latency: got req=%b busy=%b, want 1 1", wr_req_o, busy_o);
    end
    @(negedge wr_clk_i);
    checks++;
    if (wr_req_o !== 1'b0 || src_grant_o !== '0) begin
      errors++;
      $display("FAIL single_req_release: got req=%b grant=%b, want req=0 grant=0", wr_req_o, src_grant_o);
    end
    exp_src_q.push_back(1);
    // Grant must appear on the very next sample after ack dropped.
    s = exp_src_q.pop_front();
    @(negedge wr_clk_i);
    checks++;
    if (src_grant_o !== (N'(1) << s)) begin
      errors++;
      $display("FAIL single_grant: got %b, want %b", src_grant_o, N'(1) << s);
    end
    serve(1, 16, 1'b0);
  endtask

  task automatic test_round_robin();
    int s;
    src_req_i = '1;
    exp_src_q.push_back(0);
    exp_src_q.push_back(1);
    exp_src_q.push_back(2);
    exp_src_q.push_back(3);
    exp_src_q.push_back(0);
    for (int k = 0; k < 5; k++) begin
      take_grant(s);
      if (k == 4) src_req_i = '0;
      if (s >= 0) serve(s, 2, k < 4);
    end
  endtask

  task automatic test_deny();
    logic [N-1:0] g, d;
    bit clean;
    int s;
    ctrl_full = 1'b1;
    src_req_i = 4'b0100;
    wait_owner(g, d);
    checks++;
    if (d !== 4'b0100 || g !== '0) begin
      errors++;
      $display("FAIL deny_pulse: got deny=%b grant=%b, want deny=0100 grant=0000", d, g);
    end
    src_req_i = '0;
    clean = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge wr_clk_i);
      if (src_deny_o !== '0 || wr_finish_o !== 1'b0 || src_grant_o !== '0 || busy_o !== 1'b0) clean = 1'b0;
    end
    checks++;
    if (!clean) begin
      errors++;
      $display("FAIL deny_aftermath: got clean=%0d (deny=%b finish=%b grant=%b busy=%b), want clean=1",
               clean, src_deny_o, wr_finish_o, src_grant_o, busy_o);
    end
    ctrl_full = 1'b0;
    src_req_i = 4'b1100;
    exp_src_q.push_back(3);
    exp_src_q.push_back(2);
    for (int k = 0; k < 2; k++) begin
      take_grant(s);
      if (s >= 0) serve(s, 2, 1'b0);
    end
  endtask

  task automatic test_ignore_others();
    int s;
    bit ok;
    src_req_i = 4'b0001;
    exp_src_q.push_back(0);
    take_grant(s);
    src_req_i[0] = 1'b0;
    src_wr_data_i[1*DW +: DW] = 8'h5A;
    src_wr_addr_i[1*AW +: AW] = 8'hA5;
    ok = 1'b1;
    for (int k = 0; k < 6; k++) begin
      src_wr_en_i[1] = k[0];
      src_done_i[1]  = (k == 2);
      #1;
      if (wr_en_o !== 1'b0) ok = 1'b0;
      @(negedge wr_clk_i);
      if (src_grant_o !== 4'b0001 || wr_finish_o !== 1'b0 || busy_o !== 1'b1) ok = 1'b0;
    end
    src_done_i[1] = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ignore_others: got ok=%0d (grant=%b finish=%b en=%b), want ok=1 grant=0001",
               ok, src_grant_o, wr_finish_o, wr_en_o);
    end
    // Producer 1 keeps strobing with its own data while producer 0 writes.
    src_wr_en_i[1] = 1'b1;
    if (s >= 0) serve(s, 3, 1'b0);
    src_wr_en_i[1] = 1'b0;
  endtask

  task automatic test_reset_in_fin();
    int s;
    ctrl_fin_stall = 1'b1;
    src_req_i = 4'b0100;
    exp_src_q.push_back(2);
    take_grant(s);
    src_done_i[2] = 1'b1;
    src_req_i[2]  = 1'b0;
    @(negedge wr_clk_i);
    src_done_i[2] = 1'b0;
    repeat (2) @(negedge wr_clk_i);
    checks++;
    if (wr_finish_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL fin_stall_hold: got finish=%b busy=%b, want 1 1", wr_finish_o, busy_o);
    end
    #2 rst_n_i = 1'b0;
    #1;
    checks++;
    if ({wr_req_o, wr_finish_o, src_grant_o, src_deny_o, busy_o, wr_en_o, cur_src_o, timeout_err_o} !== '0) begin
      errors++;
      $display("FAIL async_reset_in_fin: got req=%b fin=%b grant=%b deny=%b busy=%b en=%b cur=%0d terr=%b, want all 0",
               wr_req_o, wr_finish_o, src_grant_o, src_deny_o, busy_o, wr_en_o, cur_src_o, timeout_err_o);
    end
    src_req_i      = 4'b1001;
    ctrl_fin_stall = 1'b0;
    @(negedge wr_clk_i);
    rst_n_i = 1'b1;
    exp_src_q.push_back(0);
    exp_src_q.push_back(3);
    for (int k = 0; k < 2; k++) begin
      take_grant(s);
      if (s >= 0) serve(s, 2, 1'b0);
    end
  endtask

`ifdef BUF_WR_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int  high_cycles;
    bit  seen;
    bit  sticky;
    ctrl_req_stall = 1'b1;
    src_req_i = 4'b0001;
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge wr_clk_i);
      if (wr_req_o) seen = 1'b1;
    end
    high_cycles = 0;
    while (seen && wr_req_o && high_cycles < 40) begin
      high_cycles++;
      @(negedge wr_clk_i);
    end
    checks++;
    if (high_cycles != TO) begin
      errors++;
      $display("FAIL timeout_req_len: got %0d cycles of wr_req_o, want %0d", high_cycles, TO);
    end
    checks++;
    if (src_deny_o !== 4'b0001 || timeout_err_o !== 1'b1) begin
      errors++;
      $display("FAIL timeout_deny: got deny=%b terr=%b, want deny=0001 terr=1", src_deny_o, timeout_err_o);
    end
    src_req_i      = '0;
    ctrl_req_stall = 1'b0;
    sticky = 1'b1;
    repeat (6) begin
      @(negedge wr_clk_i);
      if (timeout_err_o !== 1'b1 || busy_o !== 1'b0) sticky = 1'b0;
    end
    checks++;
    if (!sticky) begin
      errors++;
      $display("FAIL timeout_sticky: got terr=%b busy=%b, want terr=1 busy=0", timeout_err_o, busy_o);
    end
    do_reset();
    #1;
    checks++;
    if (timeout_err_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: got terr=%b after reset, want 0", timeout_err_o);
    end
  endtask
`else
  task automatic test_no_timeout();
    int s;
    bit held;
    ctrl_req_stall = 1'b1;
    src_req_i = 4'b0010;
    held = 1'b1;
    @(negedge wr_clk_i);
    repeat (20) begin
      @(negedge wr_clk_i);
      if (wr_req_o !== 1'b1 || timeout_err_o !== 1'b0 || src_deny_o !== '0) held = 1'b0;
    end
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL no_timeout_wait: got req=%b terr=%b deny=%b, want req=1 terr=0 deny=0",
               wr_req_o, timeout_err_o, src_deny_o);
    end
    ctrl_req_stall = 1'b0;
    exp_src_q.push_back(1);
    take_grant(s);
    if (s >= 0) serve(s, 2, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    do_reset();
    test_round_robin();
    test_deny();
    test_ignore_others();
    test_reset_in_fin();
`ifdef BUF_WR_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    repeat (2) @(negedge wr_clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
